mem_copy_engine: RTL and testbench
==================================

# mem_copy_engine

Single-channel block-copy initiator driving the 16-bit word-addressed single-port memory interface (enable/wr/addr, combinational read, write on rising edge). Given a source address, destination address and word count, it reads each word, registers it, and writes it back, one memory access per cycle, with a start/busy/done handshake toward the control logic. It sits between the control path and the memory port, and also serves as the bench's memory-initialization and relocation helper.

## Interface
- ADDR_W, 16, memory address width in words
- DATA_W, 16, memory word width
- DUMP_ON_DONE, 0, when 1, assert mem_createdump for the DONE cycle

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a copy; sampled only in IDLE
- src_addr  in  ADDR_W  first source word address; captured on accepted start
- dst_addr  in  ADDR_W  first destination word address; captured on accepted start
- len  in  ADDR_W  words to copy; captured on accepted start; 0 is legal
- busy  out  1  high in READ and WRITE
- done  out  1  one-cycle pulse in DONE
- xfer_count  out  ADDR_W  words written so far in the current/last copy
- mem_enable  out  1  memory enable
- mem_wr  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid combinationally when mem_enable & ~mem_wr
- mem_createdump  out  1  memory dump request

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: all mem_* outputs 0. On start=1, latch src, dst and len, clear idx and xfer_count. Go to READ if len!=0, else DONE.
- READ: mem_enable=1, mem_wr=0, mem_addr=src+idx. On the edge, capture mem_rdata into the data register and go to WRITE.
- WRITE: mem_enable=1, mem_wr=1, mem_addr=dst+idx, mem_wdata=data register. On the edge, idx++ and xfer_count++. Go to DONE if idx+1==len, else READ.
- DONE: done=1, plus mem_createdump=1 if DUMP_ON_DONE. mem_enable=0. Next state is IDLE unconditionally. A start in DONE is ignored.
- start while busy or in DONE is ignored; no queuing.
- Address arithmetic is modulo 2^ADDR_W. src+idx and dst+idx wrap past 0xFFFF to 0x0000 silently.
- Copy is strictly ascending-order, word by word. With overlapping ranges where dst>src, already-written words are re-read (propagation). This is defined behaviour, not an error.
- len is compared as unsigned. len=0xFFFF copies 65535 words.
- mem_wdata is 0 outside WRITE. mem_addr is 0 in IDLE and DONE.
- xfer_count holds its final value through DONE and IDLE until the next accepted start.

## Timing
- Reset: state=IDLE; busy=0, done=0, xfer_count=0, mem_enable=0, mem_wr=0, mem_addr=0, mem_wdata=0, mem_createdump=0. The data register is cleared.
- rst mid-copy: the next edge returns to IDLE with all outputs as above. The memory write in the cycle where rst is high is not guaranteed and must not be relied on. No done pulse is issued.
- Outputs are Moore, decoded from registered state, idx and latched addresses. The only combinational input path is mem_rdata into the data register.
- Start accepted at edge k gives the first READ cycle in k..k+1.
- Each word takes exactly 2 cycles: READ, then WRITE. Throughput is 1 word per 2 cycles.
- For len=N>0, done is high in the cycle 2N+1 cycles after the accepting edge.
- For len=0, done is high in the cycle immediately after the accepting edge.
- After DONE, a new start is accepted on the edge following the first IDLE cycle at the earliest (minimum 1 idle cycle between copies).
- mem_enable never asserts with mem_wr=1 in READ. No concurrent read and write ever occurs.

## Test plan
- Basic copy: preload mem[0x0010..0x0013] = 0x1111, 0x2222, 0x3333, 0x4444. Start with src=0x0010, dst=0x0100, len=4. Required: mem[0x0100..0x0103] matches, done exactly 9 cycles after the accepting edge, xfer_count=4, busy high for 8 cycles.
- Zero length: start with len=0. Required: done in the next cycle, mem_enable never asserted, xfer_count=0.
- Wrap-around: src=0xFFFE, dst=0x0002, len=4, with mem[0xFFFE]=0xAAAA, mem[0xFFFF]=0xBBBB, mem[0]=0xCCCC, mem[1]=0xDDDD. Required: mem[2..5] = AAAA, BBBB, CCCC, DDDD.
- Overlap propagation: mem[0x20]=0x5A5A, src=0x20, dst=0x21, len=3. Required: mem[0x21..0x23] all 0x5A5A.
- Start while busy, plus reset mid-copy: pulse start during the 2nd word of a len=8 copy. Required: the pulse is ignored and done arrives at the original time. Then assert rst at the 5th WRITE of a new copy. Required: the next cycle is IDLE with all outputs 0 and no done pulse. A subsequent len=1 copy completes normally.
- DUMP_ON_DONE=1: run a len=2 copy. Required: mem_createdump high only in the done cycle, and the dumpfile contains the copied words.

Source files
------------

// File: rtl/mem_copy_engine.sv
// mem_copy_engine
// Single-channel block-copy initiator for a word-addressed single-port memory
// (combinational read, write on rising edge). For each word it issues one READ
// cycle, registers the returned data, then issues one WRITE cycle. Copies run
// in strictly ascending order, so overlapping ranges with dst > src propagate
// already-written words.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           copy request, sampled only in IDLE
//   src_addr        first source word address, captured on accepted start
//   dst_addr        first destination word address, captured on accepted start
//   len             number of words to copy (0 is legal), captured on start
//   busy            high during READ and WRITE
//   done            one-cycle completion pulse
//   xfer_count      words written in the current/last copy
//   mem_enable      memory enable
//   mem_wr          memory write strobe
//   mem_addr        memory word address
//   mem_wdata       memory write data
//   mem_rdata       memory read data (combinational)
//   mem_createdump  dump request, raised in the done cycle when DUMP_ON_DONE
module mem_copy_engine #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter bit DUMP_ON_DONE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] xfer_count,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_createdump
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] idx_inc;

  // idx counts completed writes, so it doubles as the visible transfer count.
  assign idx_inc    = idx_q + ADDR_W'(1);
  assign xfer_count = idx_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = len;
          idx_d   = '0;
          state_d = (len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        data_d  = mem_rdata;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        idx_d = idx_inc;
        // Unsigned compare of the post-increment count; len=all-ones is a
        // full 2^ADDR_W-1 word copy.
        state_d = (idx_inc == len_q) ? S_DONE : S_READ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    mem_enable     = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_createdump = 1'b0;
    unique case (state_q)
      S_READ: begin
        busy       = 1'b1;
        mem_enable = 1'b1;
        mem_addr   = src_q + idx_q;
      end
      S_WRITE: begin
        busy       = 1'b1;
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = dst_q + idx_q;
        mem_wdata  = data_q;
      end
      S_DONE: begin
        done           = 1'b1;
        mem_createdump = DUMP_ON_DONE;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (no dump)
  logic        rst, start;
  logic [15:0] src_addr, dst_addr, len;
  logic        busy, done, mem_enable, mem_wr, mem_createdump;
  logic [15:0] xfer_count, mem_addr, mem_wdata, mem_rdata;

  // Second instance with dump on done
  logic        start2;
  logic [15:0] src2, dst2, len2;
  logic        busy2, done2, en2, wr2, dump2;
  logic [15:0] xfer2, addr2, wdata2, rdata2;

  logic [15:0] mem     [0:65535];
  logic [15:0] mem2    [0:65535];
  logic [15:0] ref_mem [0:65535];

  // Preload / fill port into the bench memories (single writing process)
  logic        fill_req, pl_en, pl_sel;
  logic [15:0] pl_addr, pl_data;

  int checks = 0;
  int passes = 0;

  mem_copy_engine #(.ADDR_W(16), .DATA_W(16), .DUMP_ON_DONE(1'b0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done(done), .xfer_count(xfer_count),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_createdump(mem_createdump)
  );

  mem_copy_engine #(.ADDR_W(16), .DATA_W(16), .DUMP_ON_DONE(1'b1)) u_dut_dump (
    .clk(clk), .rst(rst), .start(start2), .src_addr(src2), .dst_addr(dst2),
    .len(len2), .busy(busy2), .done(done2), .xfer_count(xfer2),
    .mem_enable(en2), .mem_wr(wr2), .mem_addr(addr2),
    .mem_wdata(wdata2), .mem_rdata(rdata2), .mem_createdump(dump2)
  );

  function automatic logic [15:0] fill_pat(input int a);
    logic [31:0] t;
    t = a * 32'd40503;
    return t[15:0] ^ 16'h5A3C;
  endfunction

  assign mem_rdata = (mem_enable && !mem_wr) ? mem[mem_addr] : 16'h0;
  assign rdata2    = (en2 && !wr2) ? mem2[addr2] : 16'h0;

  always @(posedge clk) begin
    if (fill_req) begin
      for (int a = 0; a < 65536; a++) begin
        mem[a]  <= fill_pat(a);
        mem2[a] <= fill_pat(a);
      end
    end
    if (pl_en) begin
      if (pl_sel) mem2[pl_addr] <= pl_data;
      else        mem[pl_addr]  <= pl_data;
    end
    if (mem_enable && mem_wr) mem[mem_addr] <= mem_wdata;
    if (en2 && wr2) mem2[addr2] <= wdata2;
  end

  // Reference: ascending word-by-word copy with 16-bit address wrap.
  function automatic void apply_ref(input logic [15:0] s, input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] sa, da;
      sa = s + 16'(i);
      da = d + 16'(i);
      ref_mem[da] = ref_mem[sa];
    end
  endfunction

  function automatic int count_mismatch();
    int m = 0;
    for (int a = 0; a < 65536; a++)
      if (mem[a] !== ref_mem[a]) m++;
    return m;
  endfunction

  task automatic preload(input bit sel, input logic [15:0] a, input logic [15:0] d);
    pl_sel = sel; pl_addr = a; pl_data = d; pl_en = 1'b1;
    if (!sel) ref_mem[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Runs one copy on the main instance; entered and left at a negedge in IDLE.
  // pulse_at>0 raises start for one cycle at that cycle index (while busy).
  task automatic do_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                         input int pulse_at, output int done_at, output int busy_cnt,
                         output int en_cnt, output int dump_cnt, output logic [15:0] xfer_at_done);
    int budget;
    budget = 2 * int'(n) + 20;
    done_at = 0; busy_cnt = 0; en_cnt = 0; dump_cnt = 0; xfer_at_done = 16'hxxxx;
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    src_addr = 16'($urandom); dst_addr = 16'($urandom); len = 16'($urandom);
    for (int c = 1; c <= budget; c++) begin
      if (busy) busy_cnt++;
      if (mem_enable) en_cnt++;
      if (mem_createdump) dump_cnt++;
      if (done) begin
        done_at = c;
        xfer_at_done = xfer_count;
        break;
      end
      if (c == pulse_at) begin
        start = 1'b1; src_addr = 16'($urandom); dst_addr = 16'($urandom);
        len = 16'($urandom_range(1, 5));
      end else if (c == pulse_at + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    $display("copy src=%h dst=%h len=%0d done_at=%0d busy=%0d xfer=%0d", s, d, n, done_at, busy_cnt, xfer_at_done);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, mem_enable, mem_wr, mem_createdump} !== 5'b0) $display("FAIL reset_flags got=%b want=00000", {busy, done, mem_enable, mem_wr, mem_createdump});
    else passes++;
    checks++;
    if (xfer_count !== 16'h0) $display("FAIL reset_xfer got=%h want=0000", xfer_count); else passes++;
    checks++;
    if ({mem_addr, mem_wdata} !== 32'h0) $display("FAIL reset_addr_wdata got=%h want=0", {mem_addr, mem_wdata}); else passes++;
    checks++;
    if ({busy2, done2, en2, wr2, dump2} !== 5'b0) $display("FAIL reset_dump_inst got=%b want=00000", {busy2, done2, en2, wr2, dump2});
    else passes++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int da, bc, ec, dc; logic [15:0] xf; int mm;
    preload(0, 16'h0010, 16'h1111); preload(0, 16'h0011, 16'h2222);
    preload(0, 16'h0012, 16'h3333); preload(0, 16'h0013, 16'h4444);
    do_copy(16'h0010, 16'h0100, 16'd4, 0, da, bc, ec, dc, xf);
    apply_ref(16'h0010, 16'h0100, 4);
    checks++; if (da !== 9)  $display("FAIL basic_done_time got=%0d want=9", da); else passes++;
    checks++; if (bc !== 8)  $display("FAIL basic_busy_cycles got=%0d want=8", bc); else passes++;
    checks++; if (xf !== 16'd4) $display("FAIL basic_xfer got=%0d want=4", xf); else passes++;
    checks++; if (mem[16'h0103] !== 16'h4444) $display("FAIL basic_last_word got=%h want=4444", mem[16'h0103]); else passes++;
    mm = count_mismatch();
    checks++; if (mm !== 0) $display("FAIL basic_image mismatches=%0d want=0", mm); else passes++;
    checks++; if (xfer_count !== 16'd4) $display("FAIL basic_xfer_hold got=%0d want=4", xfer_count); else passes++;
    checks++; if (dc !== 0) $display("FAIL basic_no_dump got=%0d want=0", dc); else passes++;
  endtask

  task automatic test_zero_len();
    int da, bc, ec, dc; logic [15:0] xf; int mm;
    do_copy(16'($urandom), 16'($urandom), 16'd0, 0, da, bc, ec, dc, xf);
    checks++; if (da !== 1) $display("FAIL zero_done_time got=%0d want=1", da); else passes++;
    checks++; if (ec !== 0) $display("FAIL zero_mem_enable got=%0d want=0", ec); else passes++;
    checks++; if (xf !== 16'd0) $display("FAIL zero_xfer got=%0d want=0", xf); else passes++;
    mm = count_mismatch();
    checks++; if (mm !== 0) $display("FAIL zero_image mismatches=%0d want=0", mm); else passes++;
  endtask

  task automatic test_wrap();
    int da, bc, ec, dc; logic [15:0] xf; int mm;
    logic [15:0] want [4];
    want = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    preload(0, 16'hFFFE, 16'hAAAA); preload(0, 16'hFFFF, 16'hBBBB);
    preload(0, 16'h0000, 16'hCCCC); preload(0, 16'h0001, 16'hDDDD);
    do_copy(16'hFFFE, 16'h0002, 16'd4, 0, da, bc, ec, dc, xf);
    apply_ref(16'hFFFE, 16'h0002, 4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[2 + i] !== want[i]) $display("FAIL wrap_word%0d got=%h want=%h", i, mem[2 + i], want[i]);
      else passes++;
    end
    mm = count_mismatch();
    checks++; if (mm !== 0) $display("FAIL wrap_image mismatches=%0d want=0", mm); else passes++;
  endtask

  task automatic test_overlap();
    int da, bc, ec, dc; logic [15:0] xf; int mm, bad;
    preload(0, 16'h0020, 16'h5A5A);
    do_copy(16'h0020, 16'h0021, 16'd3, 0, da, bc, ec, dc, xf);
    apply_ref(16'h0020, 16'h0021, 3);
    bad = 0;
    for (int a = 16'h21; a <= 16'h23; a++) if (mem[a] !== 16'h5A5A) bad++;
    checks++; if (bad !== 0) $display("FAIL overlap_propagate bad_words=%0d want=0", bad); else passes++;
    mm = count_mismatch();
    checks++; if (mm !== 0) $display("FAIL overlap_image mismatches=%0d want=0", mm); else passes++;
  endtask

  task automatic test_start_while_busy();
    int da, bc, ec, dc; logic [15:0] xf; int mm;
    do_copy(16'h0300, 16'h0400, 16'd8, 3, da, bc, ec, dc, xf);
    apply_ref(16'h0300, 16'h0400, 8);
    checks++; if (da !== 17) $display("FAIL busy_start_done_time got=%0d want=17", da); else passes++;
    checks++; if (xf !== 16'd8) $display("FAIL busy_start_xfer got=%0d want=8", xf); else passes++;
    mm = count_mismatch();
    checks++; if (mm !== 0) $display("FAIL busy_start_image mismatches=%0d want=0", mm); else passes++;
  endtask

  task automatic test_reset_mid_copy();
    int da, bc, ec, dc; logic [15:0] xf; int mm, done_seen;
    src_addr = 16'h0500; dst_addr = 16'h0600; len = 16'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Cycle 1 is the first READ; the 5th WRITE falls in cycle 10.
    for (int c = 1; c < 10; c++) @(negedge clk);
    checks++; if (mem_wr !== 1'b1) $display("FAIL rst_mid_in_write got=%b want=1", mem_wr); else passes++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, mem_enable, mem_wr, mem_createdump, xfer_count, mem_addr, mem_wdata} !== 53'h0)
      $display("FAIL rst_mid_outputs got=%b%b%b%b%b %h %h %h want=all zero", busy, done, mem_enable, mem_wr, mem_createdump, xfer_count, mem_addr, mem_wdata);
    else passes++;
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (done || busy) done_seen++;
      @(negedge clk);
    end
    checks++; if (done_seen !== 0) $display("FAIL rst_mid_no_done active_cycles=%0d want=0", done_seen); else passes++;
    apply_ref(16'h0500, 16'h0600, 4);
    ref_mem[16'h0604] = mem[16'h0604]; // write coinciding with rst is not guaranteed
    mm = count_mismatch();
    checks++; if (mm !== 0) $display("FAIL rst_mid_image mismatches=%0d want=0", mm); else passes++;
    do_copy(16'h0700, 16'h0800, 16'd1, 0, da, bc, ec, dc, xf);
    apply_ref(16'h0700, 16'h0800, 1);
    checks++; if (da !== 3) $display("FAIL rst_after_done_time got=%0d want=3", da); else passes++;
    checks++; if (xf !== 16'd1) $display("FAIL rst_after_xfer got=%0d want=1", xf); else passes++;
    mm = count_mismatch();
    checks++; if (mm !== 0) $display("FAIL rst_after_image mismatches=%0d want=0", mm); else passes++;
  endtask

  task automatic test_random();
    int da, bc, ec, dc; logic [15:0] xf; int mm;
    logic [15:0] s, d, n;
    for (int it = 0; it < 20; it++) begin
      s = 16'($urandom);
      d = (it % 4 == 0) ? s + 16'($urandom_range(1, 6)) : 16'($urandom);
      n = 16'($urandom_range(1, 20));
      do_copy(s, d, n, 0, da, bc, ec, dc, xf);
      apply_ref(s, d, int'(n));
      checks++; if (da !== 2 * int'(n) + 1) $display("FAIL rand%0d_done_time got=%0d want=%0d", it, da, 2 * int'(n) + 1); else passes++;
      checks++; if (bc !== 2 * int'(n)) $display("FAIL rand%0d_busy got=%0d want=%0d", it, bc, 2 * int'(n)); else passes++;
      checks++; if (xf !== n) $display("FAIL rand%0d_xfer got=%0d want=%0d", it, xf, n); else passes++;
      mm = count_mismatch();
      checks++; if (mm !== 0) $display("FAIL rand%0d_image mismatches=%0d want=0", it, mm); else passes++;
    end
  endtask

  task automatic test_dump();
    int done_at, dump_cnt, stray, late;
    logic [15:0] got0, got1;
    preload(1, 16'h0040, 16'h1234); preload(1, 16'h0041, 16'h5678);
    src2 = 16'h0040; dst2 = 16'h0080; len2 = 16'd2; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    done_at = 0; dump_cnt = 0; stray = 0; late = 0; got0 = 16'hxxxx; got1 = 16'hxxxx;
    for (int c = 1; c <= 30; c++) begin
      if (dump2) begin
        dump_cnt++;
        if (!done2) stray++;
        got0 = mem2[16'h0080];
        got1 = mem2[16'h0081];
      end
      if (done2) begin
        done_at = c;
        break;
      end
      @(negedge clk);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (dump2) late++;
    end
    $display("dump copy src=0040 dst=0080 len=2 done_at=%0d dumps=%0d", done_at, dump_cnt);
    checks++; if (done_at !== 5) $display("FAIL dump_done_time got=%0d want=5", done_at); else passes++;
    checks++; if (dump_cnt !== 1 || stray !== 0 || late !== 0)
      $display("FAIL dump_pulse count=%0d stray=%0d late=%0d want=1/0/0", dump_cnt, stray, late);
    else passes++;
    checks++; if (got0 !== 16'h1234) $display("FAIL dump_word0 got=%h want=1234", got0); else passes++;
    checks++; if (got1 !== 16'h5678) $display("FAIL dump_word1 got=%h want=5678", got1); else passes++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
    src2 = '0; dst2 = '0; len2 = '0;
    pl_en = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_data = '0;
    fill_req = 1'b1;
    for (int a = 0; a < 65536; a++) ref_mem[a] = fill_pat(a);

    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_overlap();
    test_start_while_busy();
    test_reset_mid_copy();
    test_random();
    test_dump();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
